// File: rtl/mem_port_arbiter_if.sv
// Memory request bus: valid/addr_ok/data_ok handshake, NumPorts requesters sharing one rdata.
// The arbiter's upstream side uses NumPorts = 2 and its downstream side uses NumPorts = 1.
interface mem_port_arbiter_if #(
    parameter int unsigned NumPorts = 1,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32
);
    logic [NumPorts-1:0]          valid;
    logic [NumPorts*AW-1:0]       addr;
    logic [NumPorts*3-1:0]        size;
    logic [NumPorts*(DW/8)-1:0]   strobe;
    logic [NumPorts*DW-1:0]       wdata;
    logic [NumPorts-1:0]          addr_ok;
    logic [NumPorts-1:0]          data_ok;
    logic [DW-1:0]                rdata;

    modport master (
        output valid, addr, size, strobe, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  valid, addr, size, strobe, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the data bus (port 0) and the instruction bus (port 1).
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority with a starvation guard.
module mem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  s_bus,
    mem_port_arbiter_if.master m_bus
);

    localparam int unsigned SW = DW / 8;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e state_q, state_d;
    logic   sel_q, sel_d;
    logic   any_valid;
    logic   grant;
    logic   winner;

    logic          sel_valid;
    logic [AW-1:0] sel_addr;
    logic [2:0]    sel_size;
    logic [SW-1:0] sel_strobe;
    logic [DW-1:0] sel_wdata;

`ifdef ARB_RR_EN
    logic rr_last_q, rr_last_d;
`else
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    logic [CntW-1:0] starve_q, starve_d;
`endif

    assign any_valid = |s_bus.valid;
    assign grant     = (state_q == StIdle) && any_valid;

    // Winner is only meaningful when grant is high.
`ifdef ARB_RR_EN
    assign winner = (&s_bus.valid) ? ~rr_last_q : s_bus.valid[1];
`else
    assign winner = s_bus.valid[1] &&
                    (!s_bus.valid[0] || (starve_q == CntW'(STARVE_LIMIT)));
`endif

    assign sel_valid  = s_bus.valid[sel_q];
    assign sel_addr   = sel_q ? s_bus.addr[AW +: AW]     : s_bus.addr[0 +: AW];
    assign sel_size   = sel_q ? s_bus.size[3 +: 3]       : s_bus.size[0 +: 3];
    assign sel_strobe = sel_q ? s_bus.strobe[SW +: SW]   : s_bus.strobe[0 +: SW];
    assign sel_wdata  = sel_q ? s_bus.wdata[DW +: DW]    : s_bus.wdata[0 +: DW];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            sel_q     <= 1'b0;
`ifdef ARB_RR_EN
            rr_last_q <= 1'b1;
`else
            starve_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
`ifdef ARB_RR_EN
            rr_last_q <= rr_last_d;
`else
            starve_q  <= starve_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    state_d = StReq;
                    sel_d   = winner;
                end
            end
            StReq: begin
                // A requester dropping valid before acceptance is a flush: abandon quietly.
                if (!sel_valid) begin
                    state_d = StIdle;
                end else if (m_bus.addr_ok[0]) begin
                    state_d = m_bus.data_ok[0] ? StIdle : StWait;
                end
            end
            StWait: begin
                if (m_bus.data_ok[0]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef ARB_RR_EN
    always_comb begin
        rr_last_d = rr_last_q;
        if (grant) begin
            rr_last_d = winner;
        end
    end
`else
    always_comb begin
        starve_d = starve_q;
        if (!s_bus.valid[1]) begin
            starve_d = '0;
        end else if (grant) begin
            if (winner) begin
                starve_d = '0;
            end else if (starve_q != CntW'(STARVE_LIMIT)) begin
                starve_d = starve_q + CntW'(1);
            end
        end
    end
`endif

    always_comb begin
        m_bus.valid   = 1'b0;
        m_bus.addr    = '0;
        m_bus.size    = '0;
        m_bus.strobe  = '0;
        m_bus.wdata   = '0;
        s_bus.addr_ok = '0;
        s_bus.data_ok = '0;
        s_bus.rdata   = '0;
        unique case (state_q)
            StReq: begin
                m_bus.valid  = sel_valid;
                m_bus.addr   = sel_addr;
                m_bus.size   = sel_size;
                m_bus.strobe = sel_strobe;
                m_bus.wdata  = sel_wdata;
                if (sel_valid && m_bus.addr_ok[0]) begin
                    s_bus.addr_ok[sel_q] = 1'b1;
                    if (m_bus.data_ok[0]) begin
                        s_bus.data_ok[sel_q] = 1'b1;
                        s_bus.rdata          = m_bus.rdata;
                    end
                end
            end
            StWait: begin
                if (m_bus.data_ok[0]) begin
                    s_bus.data_ok[sel_q] = 1'b1;
                    s_bus.rdata          = m_bus.rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: lone read, arbitration order, store, flush, reset in WAIT.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.NumPorts(2), .AW(32), .DW(32)) s_bus ();
    mem_port_arbiter_if #(.NumPorts(1), .AW(32), .DW(32)) m_bus ();

    mem_port_arbiter #(
        .AW          (32),
        .DW          (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .s_bus(s_bus),
        .m_bus(m_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_order[6];

    initial begin
        total = 0;
        bad   = 0;
`ifdef ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 1, 0};
`endif
        reset          = 1'b1;
        s_bus.valid    = '0;
        s_bus.addr     = '0;
        s_bus.size     = '0;
        s_bus.strobe   = '0;
        s_bus.wdata    = '0;
        m_bus.addr_ok  = '0;
        m_bus.data_ok  = '0;
        m_bus.rdata    = '0;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", 64'(m_bus.valid), 64'h0);
        chk("rst_addr_ok", 64'(s_bus.addr_ok), 64'h0);
        chk("rst_data_ok", 64'(s_bus.data_ok), 64'h0);
        chk("rst_rdata", 64'(s_bus.rdata), 64'h0);

        // Lone port-1 read.
        step();
        s_bus.valid       = 2'b10;
        s_bus.addr[63:32] = 32'h1000;
        s_bus.addr[31:0]  = 32'h0100;
        s_bus.size        = 6'b010_010;
        @(negedge clk);
        chk("t1_idle_m_valid", 64'(m_bus.valid), 64'h0);
        step();
        m_bus.addr_ok = 1'b1;
        @(negedge clk);
        chk("t1_m_valid", 64'(m_bus.valid), 64'h1);
        chk("t1_m_addr", 64'(m_bus.addr), 64'h1000);
        chk("t1_addr_ok", 64'(s_bus.addr_ok), 64'h2);
        chk("t1_data_ok_early", 64'(s_bus.data_ok), 64'h0);
        step();
        s_bus.valid   = 2'b00;
        m_bus.addr_ok = 1'b0;
        @(negedge clk);
        chk("t1_wait_m_valid", 64'(m_bus.valid), 64'h0);
        chk("t1_wait_data_ok", 64'(s_bus.data_ok), 64'h0);
        step();
        m_bus.data_ok = 1'b1;
        m_bus.rdata   = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_data_ok", 64'(s_bus.data_ok), 64'h2);
        chk("t1_rdata", 64'(s_bus.rdata), 64'hDEADBEEF);
        chk("t1_addr_ok_wait", 64'(s_bus.addr_ok), 64'h0);
        step();
        m_bus.data_ok = 1'b0;
        @(negedge clk);
        chk("t1_pulse", 64'(s_bus.data_ok), 64'h0);

        // Both ports valid for six transactions, each completing in its REQ cycle.
        s_bus.valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step();
            m_bus.addr_ok = 1'b1;
            m_bus.data_ok = 1'b1;
            m_bus.rdata   = 32'hA000 + 32'(i);
            @(negedge clk);
            chk($sformatf("t2_grant%0d", i), 64'(s_bus.addr_ok),
                (exp_order[i] == 1) ? 64'h2 : 64'h1);
            chk($sformatf("t2_data_ok%0d", i), 64'(s_bus.data_ok),
                (exp_order[i] == 1) ? 64'h2 : 64'h1);
            chk($sformatf("t2_m_addr%0d", i), 64'(m_bus.addr),
                (exp_order[i] == 1) ? 64'h1000 : 64'h0100);
            chk($sformatf("t2_rdata%0d", i), 64'(s_bus.rdata), 64'hA000 + 64'(i));
            step();
            m_bus.addr_ok = 1'b0;
            m_bus.data_ok = 1'b0;
            @(negedge clk);
            chk($sformatf("t2_gap%0d", i), 64'(m_bus.valid), 64'h0);
        end
        s_bus.valid = 2'b00;

        // Port-0 store with addr_ok and data_ok in the same cycle.
        step();
        s_bus.valid            = 2'b01;
        s_bus.addr[31:0]       = 32'h2000;
        s_bus.strobe[3:0]      = 4'b0011;
        s_bus.wdata[31:0]      = 32'h1234;
        step();
        m_bus.addr_ok = 1'b1;
        m_bus.data_ok = 1'b1;
        m_bus.rdata   = 32'h0;
        @(negedge clk);
        chk("t4_m_strobe", 64'(m_bus.strobe), 64'h3);
        chk("t4_m_wdata", 64'(m_bus.wdata), 64'h1234);
        chk("t4_m_size", 64'(m_bus.size), 64'h2);
        chk("t4_addr_ok", 64'(s_bus.addr_ok), 64'h1);
        chk("t4_data_ok", 64'(s_bus.data_ok), 64'h1);
        step();
        s_bus.valid   = 2'b00;
        s_bus.strobe  = '0;
        m_bus.addr_ok = 1'b0;
        // A stray data_ok here must be ignored, proving the FSM is back in IDLE.
        m_bus.data_ok = 1'b1;
        @(negedge clk);
        chk("t4_idle_m_valid", 64'(m_bus.valid), 64'h0);
        chk("t4_idle_data_ok", 64'(s_bus.data_ok), 64'h0);
        step();
        m_bus.data_ok = 1'b0;

        // Port 0 flushes while in REQ; pending port 1 is served next.
        s_bus.valid = 2'b01;
        step();
        s_bus.valid = 2'b10;
        @(negedge clk);
        chk("t5_flush_m_valid", 64'(m_bus.valid), 64'h0);
        chk("t5_flush_addr_ok", 64'(s_bus.addr_ok), 64'h0);
        step();
        @(negedge clk);
        chk("t5_idle_m_valid", 64'(m_bus.valid), 64'h0);
        step();
        m_bus.addr_ok = 1'b1;
        @(negedge clk);
        chk("t5_p1_addr_ok", 64'(s_bus.addr_ok), 64'h2);
        chk("t5_p1_m_addr", 64'(m_bus.addr), 64'h1000);
        chk("t5_p1_data_ok", 64'(s_bus.data_ok), 64'h0);
        step();
        s_bus.valid   = 2'b00;
        m_bus.addr_ok = 1'b0;
        step();
        m_bus.data_ok = 1'b1;
        m_bus.rdata   = 32'hCAFE;
        @(negedge clk);
        chk("t5_p1_resp", 64'(s_bus.data_ok), 64'h2);
        chk("t5_p1_rdata", 64'(s_bus.rdata), 64'hCAFE);
        step();
        m_bus.data_ok = 1'b0;

        // Reset while waiting for the response drops the transaction.
        s_bus.valid      = 2'b01;
        s_bus.addr[31:0] = 32'h3000;
        step();
        m_bus.addr_ok = 1'b1;
        @(negedge clk);
        chk("t6_addr_ok", 64'(s_bus.addr_ok), 64'h1);
        step();
        s_bus.valid   = 2'b00;
        m_bus.addr_ok = 1'b0;
        reset         = 1'b1;
        step();
        reset         = 1'b0;
        m_bus.data_ok = 1'b1;
        m_bus.rdata   = 32'h5555;
        @(negedge clk);
        chk("t6_data_ok", 64'(s_bus.data_ok), 64'h0);
        chk("t6_rdata", 64'(s_bus.rdata), 64'h0);
        chk("t6_m_valid", 64'(m_bus.valid), 64'h0);
        chk("t6_addr_ok_after", 64'(s_bus.addr_ok), 64'h0);
        step();
        m_bus.data_ok = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
